rtc_reg_bank: RTL and testbench

- Parametrised register bank between the RTC address/data bus sequencer and the VGA display path.
- Holds NUM_REGS BCD time/timer registers, each at its own RTC address with its own BCD range.
- Registers capture RTC read data and accept user UP/DOWN edits.
- Tracks edited ("dirty") registers and requests their write-back to the RTC with a REQ/ACK handshake; supplies address/data bytes for bus drive.

---
 rtl/rtc_pkg.sv | 64 ++++++
 rtl/rtc_bcd_reg.sv | 59 +++++
 rtl/rtc_reg_bank.sv | 160 ++++++++++++++++
 tb/tb_rtc_reg_bank.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: shared constants and helpers for the RTC register bank.
//   - default RTC addresses and BCD limits for year/month/day/hour/minute/
//     second and the three timer registers
//   - control register addresses and values
//   - BCD increment/decrement with wrap, and a BCD range check
package rtc_pkg;

  typedef logic [7:0] bcd_t;

  // RTC addresses
  localparam bcd_t ADDR_TMR0   = 8'h41;
  localparam bcd_t ADDR_TMR1   = 8'h42;
  localparam bcd_t ADDR_TMR2   = 8'h43;
  localparam bcd_t ADDR_SEC    = 8'h21;
  localparam bcd_t ADDR_MINUTE = 8'h22;
  localparam bcd_t ADDR_HOUR   = 8'h23;
  localparam bcd_t ADDR_DAY    = 8'h24;
  localparam bcd_t ADDR_MONTH  = 8'h25;
  localparam bcd_t ADDR_YEAR   = 8'h26;

  // BCD limits
  localparam bcd_t LIM_TMR_MIN   = 8'h00, LIM_TMR_MAX   = 8'h99;
  localparam bcd_t LIM_SEC_MIN   = 8'h00, LIM_SEC_MAX   = 8'h59;
  localparam bcd_t LIM_MINUTE_MIN = 8'h00, LIM_MINUTE_MAX = 8'h59;
  localparam bcd_t LIM_HOUR_MIN  = 8'h00, LIM_HOUR_MAX  = 8'h23;
  localparam bcd_t LIM_DAY_MIN   = 8'h01, LIM_DAY_MAX   = 8'h31;
  localparam bcd_t LIM_MONTH_MIN = 8'h01, LIM_MONTH_MAX = 8'h12;
  localparam bcd_t LIM_YEAR_MIN  = 8'h00, LIM_YEAR_MAX  = 8'h99;

  // Default 9-entry tables, entry 0 in the least significant byte
  localparam logic [71:0] DEF_REG_ADDRS = {ADDR_TMR0, ADDR_TMR1, ADDR_TMR2,
                                           ADDR_SEC, ADDR_MINUTE, ADDR_HOUR,
                                           ADDR_DAY, ADDR_MONTH, ADDR_YEAR};
  localparam logic [71:0] DEF_REG_MIN = {LIM_TMR_MIN, LIM_TMR_MIN, LIM_TMR_MIN,
                                         LIM_SEC_MIN, LIM_MINUTE_MIN, LIM_HOUR_MIN,
                                         LIM_DAY_MIN, LIM_MONTH_MIN, LIM_YEAR_MIN};
  localparam logic [71:0] DEF_REG_MAX = {LIM_TMR_MAX, LIM_TMR_MAX, LIM_TMR_MAX,
                                         LIM_SEC_MAX, LIM_MINUTE_MAX, LIM_HOUR_MAX,
                                         LIM_DAY_MAX, LIM_MONTH_MAX, LIM_YEAR_MAX};

  // Control registers
  localparam bcd_t RTC_CTRL0_ADDR  = 8'h00;
  localparam bcd_t RTC_CTRL0_VAL   = 8'h04;
  localparam bcd_t RTC_CTRL2_ADDR  = 8'h02;
  localparam bcd_t RTC_CTRL2_FIRST = 8'h10;
  localparam bcd_t RTC_CTRL2_NEXT  = 8'h00;

  function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t mn, input bcd_t mx);
    if (v == mx)             return mn;
    else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'h1};
  endfunction

  function automatic bcd_t bcd_dec(input bcd_t v, input bcd_t mn, input bcd_t mx);
    if (v == mn)             return mx;
    else if (v[3:0] == 4'h0) return {v[7:4] - 4'h1, 4'h9};
    else                     return {v[7:4], v[3:0] - 4'h1};
  endfunction

  function automatic logic bcd_in_range(input bcd_t v, input bcd_t mn, input bcd_t mx);
    return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9) && (v >= mn) && (v <= mx);
  endfunction

endpackage

// File: rtl/rtc_bcd_reg.sv
// rtc_bcd_reg: one BCD time/timer register with wrap-around step and capture.
//   CLK, RST        clock, async active-high reset (value resets to MIN)
//   step_up/step_dn one-cycle step requests (both set: no change)
//   capture, data   load data from the RTC read path
//   cap_err         (RTC_RANGE_CHECK_EN only) captured data was invalid
//   value           current register value
// Macro RTC_RANGE_CHECK_EN: invalid captures load MIN and flag cap_err.
module rtc_bcd_reg
  import rtc_pkg::*;
#(
  parameter bcd_t MIN = 8'h00,
  parameter bcd_t MAX = 8'h99
) (
  input  logic CLK,
  input  logic RST,
  input  logic step_up,
  input  logic step_dn,
  input  logic capture,
  input  bcd_t data,
`ifdef RTC_RANGE_CHECK_EN
  output logic cap_err,
`endif
  output bcd_t value
);

  bcd_t value_q, value_d;

  // A step takes priority over a capture in the same cycle.
  always_comb begin
    value_d = value_q;
`ifdef RTC_RANGE_CHECK_EN
    cap_err = 1'b0;
`endif
    if (step_up && !step_dn) begin
      value_d = bcd_inc(value_q, MIN, MAX);
    end else if (step_dn && !step_up) begin
      value_d = bcd_dec(value_q, MIN, MAX);
    end else if (capture) begin
`ifdef RTC_RANGE_CHECK_EN
      if (bcd_in_range(data, MIN, MAX)) begin
        value_d = data;
      end else begin
        value_d = MIN;
        cap_err = 1'b1;
      end
`else
      value_d = data;
`endif
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) value_q <= MIN;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/rtc_reg_bank.sv
// rtc_reg_bank: BCD register bank between the RTC bus sequencer and display.
//   CLK, RST                 clock, async active-high reset
//   ADDR_PH/RD_PH/WR_PH      bus phase flags; ADDR_IN current RTC address
//   BUS_IN / BUS_OUT, BUS_OE sampled bus data / byte to drive and its enable
//   EDIT_EN, SEL, UP, DOWN   user edit of register SEL (level UP/DOWN)
//   REG_FLAT                 all register values, entry i at [8i+7:8i]
//   WB_REQ, WB_ADDR, WB_ACK  write-back of edited (dirty) registers
//   ERR                      sticky capture range error
// Macro RTC_RANGE_CHECK_EN enables capture range checking and ERR.
module rtc_reg_bank
  import rtc_pkg::*;
#(
  parameter int unsigned           NUM_REGS    = 9,
  parameter int unsigned           IDX_W       = 4,
  parameter logic [NUM_REGS*8-1:0] REG_ADDRS   = DEF_REG_ADDRS,
  parameter logic [NUM_REGS*8-1:0] REG_MIN     = DEF_REG_MIN,
  parameter logic [NUM_REGS*8-1:0] REG_MAX     = DEF_REG_MAX,
  parameter bcd_t                  CTRL0_ADDR  = RTC_CTRL0_ADDR,
  parameter bcd_t                  CTRL0_VAL   = RTC_CTRL0_VAL,
  parameter bcd_t                  CTRL2_ADDR  = RTC_CTRL2_ADDR,
  parameter bcd_t                  CTRL2_FIRST = RTC_CTRL2_FIRST,
  parameter bcd_t                  CTRL2_NEXT  = RTC_CTRL2_NEXT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ADDR_PH,
  input  logic                  RD_PH,
  input  logic                  WR_PH,
  input  logic [7:0]            ADDR_IN,
  input  logic [7:0]            BUS_IN,
  output logic [7:0]            BUS_OUT,
  output logic                  BUS_OE,
  input  logic                  EDIT_EN,
  input  logic [IDX_W-1:0]      SEL,
  input  logic                  UP,
  input  logic                  DOWN,
  output logic [NUM_REGS*8-1:0] REG_FLAT,
  output logic                  WB_REQ,
  output logic [7:0]            WB_ADDR,
  input  logic                  WB_ACK,
  output logic                  ERR
);

  logic                up_s1_q, up_s2_q, dn_s1_q, dn_s2_q;
  logic [NUM_REGS-1:0] dirty_q, dirty_d;
  logic                init_q, init_d;
  bcd_t                data_q, data_d;

  logic                up_pulse, dn_pulse, sel_ok, step_ok, wb_found;
  logic [NUM_REGS-1:0] sel_hit, cap_en, step_up_v, step_dn_v, wb_hit;
  bcd_t                wb_addr;

  // Two-stage edge detect: the pulse is live in the cycle after UP/DOWN is
  // first sampled, so the register moves on the second edge.
  always_comb begin
    up_pulse = up_s1_q & ~up_s2_q;
    dn_pulse = dn_s1_q & ~dn_s2_q;
    sel_ok   = EDIT_EN && (32'(SEL) < NUM_REGS);
    step_ok  = sel_ok && (up_pulse ^ dn_pulse);
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      sel_hit[i]   = sel_ok && (32'(SEL) == i);
      step_up_v[i] = step_ok && sel_hit[i] && up_pulse;
      step_dn_v[i] = step_ok && sel_hit[i] && dn_pulse;
      // An edited register that is still pending write-back ignores reads.
      cap_en[i]    = RD_PH && (ADDR_IN == REG_ADDRS[8*i +: 8]) &&
                     !(sel_hit[i] && dirty_q[i]);
    end
  end

  // Lowest-index dirty register
  always_comb begin
    wb_found = 1'b0;
    wb_hit   = '0;
    wb_addr  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (dirty_q[i] && !wb_found) begin
        wb_found  = 1'b1;
        wb_hit[i] = 1'b1;
        wb_addr   = REG_ADDRS[8*i +: 8];
      end
    end
  end

  // Ack clears first, then a same-cycle step re-sets: the edit wins.
  always_comb begin
    dirty_d = dirty_q;
    if (WB_ACK)  dirty_d = dirty_d & ~wb_hit;
    if (step_ok) dirty_d = dirty_d | sel_hit;
  end

  always_comb begin
    init_d = init_q | (ADDR_IN == CTRL2_ADDR);
    data_d = 8'hFF;
    if (ADDR_IN == CTRL0_ADDR)      data_d = CTRL0_VAL;
    else if (ADDR_IN == CTRL2_ADDR) data_d = init_q ? CTRL2_NEXT : CTRL2_FIRST;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ADDR_IN == REG_ADDRS[8*i +: 8]) data_d = REG_FLAT[8*i +: 8];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      up_s1_q <= 1'b0;
      up_s2_q <= 1'b0;
      dn_s1_q <= 1'b0;
      dn_s2_q <= 1'b0;
      dirty_q <= '0;
      init_q  <= 1'b0;
      data_q  <= 8'hFF;
    end else begin
      up_s1_q <= UP;
      up_s2_q <= up_s1_q;
      dn_s1_q <= DOWN;
      dn_s2_q <= dn_s1_q;
      dirty_q <= dirty_d;
      init_q  <= init_d;
      data_q  <= data_d;
    end
  end

`ifdef RTC_RANGE_CHECK_EN
  logic [NUM_REGS-1:0] cap_err;
  logic                err_q, err_d;

  always_comb err_d = err_q | (|cap_err);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign ERR = err_q;
`else
  assign ERR = 1'b0;
`endif

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    rtc_bcd_reg #(
      .MIN (REG_MIN[8*g +: 8]),
      .MAX (REG_MAX[8*g +: 8])
    ) u_reg (
      .CLK     (CLK),
      .RST     (RST),
      .step_up (step_up_v[g]),
      .step_dn (step_dn_v[g]),
      .capture (cap_en[g]),
      .data    (BUS_IN),
`ifdef RTC_RANGE_CHECK_EN
      .cap_err (cap_err[g]),
`endif
      .value   (REG_FLAT[8*g +: 8])
    );
  end

  assign WB_REQ  = |dirty_q;
  assign WB_ADDR = wb_addr;
  assign BUS_OUT = ADDR_PH ? ADDR_IN : data_q;
  assign BUS_OE  = ADDR_PH | WR_PH;

endmodule

// File: tb/tb_rtc_reg_bank.sv
// Testbench for rtc_reg_bank: directed stimulus pushes expectations into a
// queue; a negedge monitor pops and compares against the DUT outputs.
module tb_rtc_reg_bank;

  logic        CLK = 1'b0;
  logic        RST, ADDR_PH, RD_PH, WR_PH, EDIT_EN, UP, DOWN, WB_ACK;
  logic [7:0]  ADDR_IN, BUS_IN, BUS_OUT, WB_ADDR;
  logic [3:0]  SEL;
  logic [71:0] REG_FLAT;
  logic        BUS_OE, WB_REQ, ERR;

`ifdef RTC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef enum int {K_REG, K_WBREQ, K_WBADDR, K_BUSOUT, K_BUSOE, K_ERR} kind_e;
  typedef struct {
    string      name;
    kind_e      kind;
    int         idx;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  exp_t       cur;
  logic [7:0] got;
  int         checks = 0;
  int         errors = 0;

  // Expected reset values, index 0..8: year, month, day, hour, minute,
  // second, timer 0x43, 0x42, 0x41
  logic [7:0] exp_min [9] = '{8'h01 - 8'h01, 8'h01, 8'h01, 8'h00, 8'h00,
                              8'h00, 8'h00, 8'h00, 8'h00};

  always #5 CLK = ~CLK;

  rtc_reg_bank dut (
    .CLK      (CLK),
    .RST      (RST),
    .ADDR_PH  (ADDR_PH),
    .RD_PH    (RD_PH),
    .WR_PH    (WR_PH),
    .ADDR_IN  (ADDR_IN),
    .BUS_IN   (BUS_IN),
    .BUS_OUT  (BUS_OUT),
    .BUS_OE   (BUS_OE),
    .EDIT_EN  (EDIT_EN),
    .SEL      (SEL),
    .UP       (UP),
    .DOWN     (DOWN),
    .REG_FLAT (REG_FLAT),
    .WB_REQ   (WB_REQ),
    .WB_ADDR  (WB_ADDR),
    .WB_ACK   (WB_ACK),
    .ERR      (ERR)
  );

  task automatic chk(input string name, input kind_e k, input int idx, input logic [7:0] e);
    exp_t x;
    x.name = name;
    x.kind = k;
    x.idx  = idx;
    x.exp  = e;
    sb.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] actual(input kind_e k, input int idx);
    case (k)
      K_REG:    return REG_FLAT[8*idx +: 8];
      K_WBREQ:  return {7'b0, WB_REQ};
      K_WBADDR: return WB_ADDR;
      K_BUSOUT: return BUS_OUT;
      K_BUSOE:  return {7'b0, BUS_OE};
      default:  return {7'b0, ERR};
    endcase
  endfunction

  // Monitor
  initial forever begin
    @(negedge CLK);
    while (sb.size() > 0) begin
      cur = sb.pop_front();
      got = actual(cur.kind, cur.idx);
      checks++;
      if (got !== cur.exp) begin
        errors++;
        $display("FAIL %s: got %02h expected %02h", cur.name, got, cur.exp);
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; ADDR_PH = 0; RD_PH = 0; WR_PH = 0; ADDR_IN = 8'h00; BUS_IN = 8'h00;
    EDIT_EN = 0; SEL = 4'd0; UP = 0; DOWN = 0; WB_ACK = 0;

    // Reset state
    for (int i = 0; i < 9; i++) chk($sformatf("reset_reg%0d", i), K_REG, i, exp_min[i]);
    chk("reset_wbreq", K_WBREQ, 0, 8'h00);
    chk("reset_busoe", K_BUSOE, 0, 8'h00);
    chk("reset_busout", K_BUSOUT, 0, 8'hFF);
    chk("reset_err", K_ERR, 0, 8'h00);
    tick(2);
    RST = 1'b0;

    // Control registers
    ADDR_IN = 8'h02; tick(1); chk("ctrl2_first", K_BUSOUT, 0, 8'h10);
    tick(1); chk("ctrl2_next", K_BUSOUT, 0, 8'h00);
    ADDR_IN = 8'h00; tick(1); chk("ctrl0", K_BUSOUT, 0, 8'h04);

    // Seconds to 59 via capture, then edit
    RD_PH = 1; ADDR_IN = 8'h21; BUS_IN = 8'h59; tick(1); RD_PH = 0;
    chk("sec_capture", K_REG, 5, 8'h59);
    EDIT_EN = 1; SEL = 4'd5; UP = 1;
    tick(1); chk("sec_up_latency", K_REG, 5, 8'h59);
    tick(1); chk("sec_up_wrap", K_REG, 5, 8'h00);
    chk("sec_up_wbreq", K_WBREQ, 0, 8'h01);
    chk("sec_up_wbaddr", K_WBADDR, 0, 8'h21);
    tick(2); chk("sec_up_hold", K_REG, 5, 8'h00);
    UP = 0; tick(1);
    DOWN = 1; tick(2); chk("sec_down_wrap", K_REG, 5, 8'h59);
    DOWN = 0;
    WB_ACK = 1; tick(1); WB_ACK = 0;
    chk("sec_ack_wbreq", K_WBREQ, 0, 8'h00);
    chk("sec_ack_wbaddr", K_WBADDR, 0, 8'h00);

    // Capture and capture suppression on hour
    RD_PH = 1; ADDR_IN = 8'h23; BUS_IN = 8'h17; tick(1); RD_PH = 0;
    chk("hour_capture", K_REG, 3, 8'h17);
    SEL = 4'd3; UP = 1; tick(2); UP = 0;
    chk("hour_up", K_REG, 3, 8'h18);
    chk("hour_wbaddr", K_WBADDR, 0, 8'h23);
    RD_PH = 1; ADDR_IN = 8'h23; BUS_IN = 8'h05; tick(1); RD_PH = 0;
    chk("hour_capture_blocked", K_REG, 3, 8'h18);
    WB_ACK = 1; tick(1); WB_ACK = 0;
    chk("hour_ack", K_WBREQ, 0, 8'h00);

    // Write-back priority with indices 2 and 7 dirty
    SEL = 4'd7; UP = 1; tick(2); UP = 0; tick(1);
    SEL = 4'd2; UP = 1; tick(2); UP = 0;
    chk("tmr42_up", K_REG, 7, 8'h01);
    chk("day_up", K_REG, 2, 8'h02);
    chk("wb_prio_low", K_WBADDR, 0, 8'h24);
    WB_ACK = 1; tick(1); WB_ACK = 0;
    chk("wb_after_ack1", K_WBADDR, 0, 8'h42);
    chk("wbreq_after_ack1", K_WBREQ, 0, 8'h01);
    WB_ACK = 1; tick(1); WB_ACK = 0;
    chk("wbreq_after_ack2", K_WBREQ, 0, 8'h00);
    chk("wbaddr_after_ack2", K_WBADDR, 0, 8'h00);

    // Ack and edit of the same register in one cycle
    SEL = 4'd7; UP = 1; tick(2); UP = 0; tick(1);
    UP = 1; tick(1); WB_ACK = 1; tick(1); WB_ACK = 0; UP = 0;
    chk("ack_edit_val", K_REG, 7, 8'h03);
    chk("ack_edit_wbreq", K_WBREQ, 0, 8'h01);
    chk("ack_edit_wbaddr", K_WBADDR, 0, 8'h42);
    WB_ACK = 1; tick(1); WB_ACK = 0;
    chk("ack_edit_clear", K_WBREQ, 0, 8'h00);

    // Simultaneous UP/DOWN, out-of-range SEL
    UP = 1; DOWN = 1; tick(2);
    chk("updown_val", K_REG, 7, 8'h03);
    chk("updown_wbreq", K_WBREQ, 0, 8'h00);
    UP = 0; DOWN = 0; tick(1);
    SEL = 4'd12; UP = 1; tick(2);
    chk("badsel_wbreq", K_WBREQ, 0, 8'h00);
    chk("badsel_val", K_REG, 7, 8'h03);
    UP = 0; tick(1); EDIT_EN = 0;

    // Bus drive
    ADDR_PH = 1; ADDR_IN = 8'h25;
    chk("addr_ph_out", K_BUSOUT, 0, 8'h25);
    chk("addr_ph_oe", K_BUSOE, 0, 8'h01);
    tick(1); ADDR_PH = 0; WR_PH = 1;
    chk("wr_month", K_BUSOUT, 0, 8'h01);
    chk("wr_oe", K_BUSOE, 0, 8'h01);
    ADDR_IN = 8'h30; tick(1);
    chk("unmapped", K_BUSOUT, 0, 8'hFF);
    WR_PH = 0; RD_PH = 1;
    chk("rd_no_oe", K_BUSOE, 0, 8'h00);
    RD_PH = 0; ADDR_IN = 8'h42; tick(1);
    chk("data_tmr42", K_BUSOUT, 0, 8'h03);

    // Range checking (verbatim capture when disabled)
    RD_PH = 1; ADDR_IN = 8'h21; BUS_IN = 8'h7A; tick(1); RD_PH = 0;
    chk("bad_nibble_sec", K_REG, 5, RC ? 8'h00 : 8'h7A);
    chk("err_set", K_ERR, 0, RC ? 8'h01 : 8'h00);
    RD_PH = 1; ADDR_IN = 8'h24; BUS_IN = 8'h32; tick(1); RD_PH = 0;
    chk("day_over_max", K_REG, 2, RC ? 8'h01 : 8'h32);
    RD_PH = 1; ADDR_IN = 8'h22; BUS_IN = 8'h45; tick(1); RD_PH = 0;
    chk("minute_ok", K_REG, 4, 8'h45);
    chk("err_sticky", K_ERR, 0, RC ? 8'h01 : 8'h00);

    // Reset mid-operation
    EDIT_EN = 1; SEL = 4'd0; UP = 1; tick(2); UP = 0;
    chk("year_up", K_REG, 0, 8'h01);
    chk("year_wbreq", K_WBREQ, 0, 8'h01);
    tick(1);
    #2 RST = 1'b1;
    chk("midrst_wbreq", K_WBREQ, 0, 8'h00);
    chk("midrst_year", K_REG, 0, 8'h00);
    chk("midrst_err", K_ERR, 0, 8'h00);
    tick(1); RST = 1'b0; EDIT_EN = 0;
    ADDR_IN = 8'h02; tick(1);
    chk("ctrl2_first_again", K_BUSOUT, 0, 8'h10);

    tick(2);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
